// File: rtl/router_pkg.sv
// Shared types and constants for the router ingress block: FSM state
// encoding, default widths, and header field layout.
package router_pkg;

    localparam int DATA_W    = 8;
    localparam int NUM_PORTS = 3;

    // Header layout: [7:2] payload length, [1:0] destination
    localparam int ADDR_W       = 2;
    localparam int LEN_W        = 6;
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE,
        WAIT_EMPTY,
        LOAD_FIRST,
        LOAD_DATA,
        FULL_HOLD,
        LOAD_AFTER_FULL,
        CHECK_PARITY,
        DROP
    } state_t;

endpackage

// File: rtl/router_ingress_fsm.sv
// Packet-sequencing state machine for router_ingress: state register and
// next-state decode. Destination-specific conditions arrive pre-selected.
module router_ingress_fsm
    import router_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   pkt_valid,
    input  logic   addr_invalid,
    input  logic   empty_sel,
    input  logic   full_sel,
    input  logic   srst_sel,
    input  logic   hold_is_parity,
    output state_t state
);

    state_t state_next;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) state <= DECODE;
        else      state <= state_next;
    end

    // Next-state decode; a soft reset of the active destination aborts the packet
    always_comb begin
        state_next = state;
        if (srst_sel && state != DECODE) begin
            state_next = DECODE;
        end else begin
            case (state)
                DECODE: begin
                    if (pkt_valid) begin
                        if (addr_invalid)   state_next = DROP;
                        else if (empty_sel) state_next = LOAD_FIRST;
                        else                state_next = WAIT_EMPTY;
                    end
                end
                WAIT_EMPTY:      if (empty_sel) state_next = LOAD_FIRST;
                LOAD_FIRST:      if (!full_sel) state_next = LOAD_DATA;
                LOAD_DATA: begin
                    if (full_sel)        state_next = FULL_HOLD;
                    else if (!pkt_valid) state_next = CHECK_PARITY;
                end
                FULL_HOLD:       if (!full_sel) state_next = LOAD_AFTER_FULL;
                LOAD_AFTER_FULL: begin
                    // Full can re-assert before the held byte drains; keep holding it
                    if (full_sel)            state_next = FULL_HOLD;
                    else if (hold_is_parity) state_next = CHECK_PARITY;
                    else                     state_next = LOAD_DATA;
                end
                CHECK_PARITY:    state_next = DECODE;
                DROP:            if (!pkt_valid) state_next = DECODE;
                default:         state_next = DECODE;
            endcase
        end
    end

endmodule

// File: rtl/router_ingress.sv
// Router ingress: decodes packet headers, steers bytes into one of the
// destination FIFOs, stalls upstream on FIFO full/not-empty, and checks
// the trailing parity byte.
// Optional feature: define ROUTER_INGRESS_LEN_CHECK_EN to also compare the
// received payload byte count against the header length field.
module router_ingress #(
    parameter int DATA_W    = router_pkg::DATA_W,
    parameter int NUM_PORTS = router_pkg::NUM_PORTS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 pkt_valid,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_rst,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic [DATA_W-1:0]    dout,
    output logic                 lfd_state,
    output logic                 err,
    output logic                 parity_done
);

    import router_pkg::*;

    state_t              state;
    logic [DATA_W-1:0]   hdr;
    logic [DATA_W-1:0]   hold;
    logic                hold_is_parity;
    logic [DATA_W-1:0]   parity_acc;
    logic [DATA_W-1:0]   pkt_parity;
    logic [ADDR_W-1:0]   cur_addr;
    logic [ADDR_W-1:0]   pkt_addr;
    logic                addr_invalid;
    logic                empty_sel;
    logic                full_sel;
    logic                srst_sel;
    logic                srst_act;
    logic                wr;
    logic [DATA_W-1:0]   wr_byte;
    logic                bad_pkt;

    assign pkt_addr     = hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
    // While decoding, the destination comes straight off the header byte
    assign cur_addr     = (state == DECODE) ? data_in[HDR_ADDR_MSB:HDR_ADDR_LSB] : pkt_addr;
    assign addr_invalid = (cur_addr == ADDR_INVALID);
    assign srst_act     = srst_sel && (state != DECODE);

    // Pick the full/empty/soft-reset flags of the current destination
    always_comb begin
        empty_sel = 1'b0;
        full_sel  = 1'b0;
        srst_sel  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (cur_addr == ADDR_W'(i)) begin
                empty_sel = fifo_empty[i];
                full_sel  = fifo_full[i];
                srst_sel  = soft_rst[i];
            end
        end
    end

    router_ingress_fsm u_fsm (
        .clk            (clk),
        .rst            (rst),
        .pkt_valid      (pkt_valid),
        .addr_invalid   (addr_invalid),
        .empty_sel      (empty_sel),
        .full_sel       (full_sel),
        .srst_sel       (srst_act),
        .hold_is_parity (hold_is_parity),
        .state          (state)
    );

`ifdef ROUTER_INGRESS_LEN_CHECK_EN
    logic [LEN_W-1:0] len_cnt;

    // Count payload bytes of the current packet
    always_ff @(posedge clk) begin
        if (!rst)                               len_cnt <= '0;
        else if (state == LOAD_FIRST)           len_cnt <= '0;
        else if (state == LOAD_DATA && pkt_valid && !srst_act) len_cnt <= len_cnt + 1'b1;
    end

    assign bad_pkt = (parity_acc != pkt_parity) ||
                     (len_cnt != hdr[HDR_LEN_MSB:HDR_LEN_LSB]);
`else
    assign bad_pkt = (parity_acc != pkt_parity);
`endif

    // Header, hold, parity and error registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            hdr            <= '0;
            hold           <= '0;
            hold_is_parity <= 1'b0;
            parity_acc     <= '0;
            pkt_parity     <= '0;
            err            <= 1'b0;
        end else if (srst_act) begin
            parity_acc <= '0;
        end else begin
            case (state)
                DECODE: begin
                    if (pkt_valid) begin
                        hdr <= data_in;
                        err <= 1'b0;
                    end
                end
                LOAD_FIRST: parity_acc <= hdr;
                LOAD_DATA: begin
                    if (pkt_valid) parity_acc <= parity_acc ^ data_in;
                    else           pkt_parity <= data_in;
                    if (full_sel) begin
                        hold           <= data_in;
                        hold_is_parity <= !pkt_valid;
                    end
                end
                CHECK_PARITY: if (bad_pkt) err <= 1'b1;
                DROP:         err <= 1'b1;
                default: ;
            endcase
        end
    end

    // Output decode: stall, write strobe and write byte per state
    always_comb begin
        busy        = 1'b0;
        wr          = 1'b0;
        wr_byte     = '0;
        write_enb   = '0;
        dout        = '0;
        lfd_state   = 1'b0;
        parity_done = 1'b0;
        case (state)
            WAIT_EMPTY, FULL_HOLD, CHECK_PARITY: busy = 1'b1;
            LOAD_FIRST: begin
                busy    = 1'b1;
                wr      = !full_sel;
                wr_byte = hdr;
            end
            LOAD_DATA: begin
                wr      = !full_sel;
                wr_byte = data_in;
            end
            LOAD_AFTER_FULL: begin
                busy    = 1'b1;
                wr      = !full_sel;
                wr_byte = hold;
            end
            default: ;
        endcase
        if (!rst || srst_act) wr = 1'b0;
        if (!rst) busy = 1'b0;
        if (wr) begin
            for (int i = 0; i < NUM_PORTS; i++) write_enb[i] = (pkt_addr == ADDR_W'(i));
            dout      = wr_byte;
            lfd_state = (state == LOAD_FIRST);
        end
        parity_done = rst && (state == CHECK_PARITY);
    end

endmodule

// File: tb/tb_router_ingress.sv
// Scoreboard bench for router_ingress: directed packets, expected FIFO
// writes queued at issue time and checked by an independent monitor.
module tb_router_ingress;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       pkt_valid = 1'b0;
    logic [2:0] fifo_full = 3'b000;
    logic [2:0] fifo_empty = 3'b111;
    logic [2:0] soft_rst = 3'b000;
    logic       busy;
    logic [2:0] write_enb;
    logic [7:0] dout;
    logic       lfd_state;
    logic       err;
    logic       parity_done;

    router_ingress #(.DATA_W(8), .NUM_PORTS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .pkt_valid   (pkt_valid),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .soft_rst    (soft_rst),
        .busy        (busy),
        .write_enb   (write_enb),
        .dout        (dout),
        .lfd_state   (lfd_state),
        .err         (err),
        .parity_done (parity_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] port;
        logic [7:0] data;
        logic       lfd;
    } wr_t;

    wr_t        exp_q[$];
    int         exp_done = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] pkt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every FIFO write and every parity_done pulse is matched to the scoreboard
    always @(negedge clk) begin : monitor
        wr_t e;
        if (write_enb != 3'b000) begin
            chk("write_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("write_port_data_lfd", {write_enb, dout, lfd_state}, {e.port, e.data, e.lfd});
            end
            chk("no_write_when_full", write_enb & fifo_full, 0);
        end
        if (parity_done) begin
            chk("parity_done_expected", exp_done > 0, 1);
            if (exp_done > 0) exp_done--;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [7:0] b[$], input int nwr);
        for (int i = 0; i < nwr; i++) exp_q.push_back({3'b010, b[i], (i == 0)});
    endtask

    // Upstream source: advances one byte per cycle unless busy was high,
    // with optional full pulse, delayed empty, soft reset and busy-low check
    task automatic send(input logic [7:0] b[$], input int full_idx, input int full_cyc,
                        input int empty_wait, input int srst_idx, input bit busy0);
        int idx = 0;
        int full_left = 0;
        bit full_done = 1'b0;
        int empty_left = empty_wait;
        int guard = 0;
        bit adv;
        fifo_empty[1] = (empty_wait == 0);
        data_in = b[0];
        pkt_valid = (b.size() > 1);
        while (idx < b.size()) begin
            if (idx == full_idx && !full_done) begin
                fifo_full[1] = 1'b1;
                full_left = full_cyc;
                full_done = 1'b1;
            end
            if (idx == srst_idx) soft_rst[1] = 1'b1;
            @(negedge clk);
            if (busy0) chk("drop_busy_low", busy, 0);
            if (empty_left > 0 && idx > 0) begin
                chk("wait_busy_high", busy, 1);
                chk("wait_no_write", write_enb, 0);
            end
            adv = !busy;
            @(posedge clk);
            #1;
            if (soft_rst[1]) begin
                soft_rst[1] = 1'b0;
                break;
            end
            guard++;
            if (guard > 200) begin
                chk("driver_timeout", guard, 0);
                break;
            end
            if (adv) idx++;
            if (full_left > 0) begin
                full_left--;
                if (full_left == 0) fifo_full[1] = 1'b0;
            end
            if (empty_left > 0) begin
                empty_left--;
                if (empty_left == 0) fifo_empty[1] = 1'b1;
            end
            if (idx < b.size()) begin
                data_in = b[idx];
                pkt_valid = (idx != b.size() - 1);
            end
        end
        pkt_valid = 1'b0;
        data_in = 8'h00;
        fifo_full[1] = 1'b0;
        fifo_empty[1] = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        // Reset, with a header-like byte present to show it is ignored
        rst = 1'b0;
        data_in = 8'h0D;
        pkt_valid = 1'b1;
        cyc(3);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_write_enb", write_enb, 0);
        chk("rst_dout", dout, 0);
        chk("rst_lfd", lfd_state, 0);
        chk("rst_err", err, 0);
        chk("rst_parity_done", parity_done, 0);
        pkt_valid = 1'b0;
        data_in = 8'h00;
        cyc(1);
        rst = 1'b1;
        cyc(2);

        // Good packet to FIFO1
        pkt = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        push_wr(pkt, 5);
        exp_done++;
        send(pkt, -1, 0, 0, -1, 1'b0);
        cyc(2);
        chk("good_err", err, 0);
        chk("good_idle_busy", busy, 0);

        // Bad parity: all bytes written, err set and held
        pkt = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0E};
        push_wr(pkt, 5);
        exp_done++;
        send(pkt, -1, 0, 0, -1, 1'b0);
        cyc(2);
        chk("badpar_err", err, 1);
        cyc(4);
        chk("badpar_err_held", err, 1);

        // FIFO full while 0x22 is presented: held and written after full drops
        pkt = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        push_wr(pkt, 5);
        exp_done++;
        send(pkt, 2, 3, 0, -1, 1'b0);
        cyc(2);
        chk("full_err_cleared", err, 0);

        // Destination not empty for 4 cycles
        push_wr(pkt, 5);
        exp_done++;
        send(pkt, -1, 0, 4, -1, 1'b0);
        cyc(2);
        chk("wait_err", err, 0);

        // Invalid destination: dropped, err set
        pkt = {8'h07, 8'hAA, 8'hAD};
        send(pkt, -1, 0, 0, -1, 1'b1);
        cyc(2);
        chk("drop_err", err, 1);
        chk("drop_idle_busy", busy, 0);

        // Soft reset after 0x11 written: remaining bytes never reach the FIFO
        pkt = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        push_wr(pkt, 2);
        send(pkt, -1, 0, 0, 2, 1'b0);
        @(negedge clk);
        chk("srst_busy", busy, 0);
        chk("srst_no_write", write_enb, 0);
        cyc(4);
        chk("srst_err", err, 0);

        // Reset mid-packet: header written, then nothing more
        pkt = {8'h0D};
        push_wr(pkt, 1);
        data_in = 8'h0D;
        pkt_valid = 1'b1;
        cyc(1);
        data_in = 8'h11;
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_no_write", write_enb, 0);
        cyc(1);
        rst = 1'b1;
        pkt_valid = 1'b0;
        data_in = 8'h00;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err, 0);
        cyc(2);

        // Header says 3 payload bytes, only 2 sent; parity itself is correct
        pkt = {8'h0D, 8'h11, 8'h22, 8'h3E};
        push_wr(pkt, 4);
        exp_done++;
        send(pkt, -1, 0, 0, -1, 1'b0);
        cyc(2);
`ifdef ROUTER_INGRESS_LEN_CHECK_EN
        chk("short_pkt_err", err, 1);
`else
        chk("short_pkt_err", err, 0);
`endif

        cyc(4);
        chk("writes_outstanding", exp_q.size(), 0);
        chk("done_outstanding", exp_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
